// File: rtl/router_sw_alloc.sv
// Switch allocator: one round-robin arbiter per output port.
// Each grant is held until the packet's tail flit transfers.
// The block drives the per-flit handshake and the crossbar select.
module router_sw_alloc #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [NUM_PORTS-1:0]         req_val,
    input  logic [NUM_PORTS*SEL_W-1:0]   req_dst,
    input  logic [NUM_PORTS-1:0]         req_last,
    output logic [NUM_PORTS-1:0]         req_rdy,
    input  logic [NUM_PORTS-1:0]         out_rdy,
    output logic [NUM_PORTS-1:0]         out_val,
    output logic [NUM_PORTS*SEL_W-1:0]   out_sel,
    output logic                         bad_dst
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_PORTS - 1);

    state_t             state_q [NUM_PORTS];
    state_t             state_d [NUM_PORTS];
    logic [SEL_W-1:0]   owner_q [NUM_PORTS];
    logic [SEL_W-1:0]   owner_d [NUM_PORTS];
    logic [SEL_W-1:0]   last_q  [NUM_PORTS];
    logic [SEL_W-1:0]   last_d  [NUM_PORTS];
    logic               bad_dst_q;
    logic               bad_dst_d;

    // req_mat[o][i]: input i currently requests output o
    logic [NUM_PORTS-1:0] req_mat [NUM_PORTS];
    logic [NUM_PORTS-1:0] dst_bad;
    logic [NUM_PORTS-1:0] gnt_vld;
    logic [SEL_W-1:0]     gnt_idx [NUM_PORTS];

    // Decode each input's destination into per-output request vectors
    always_comb begin
        dst_bad = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            req_mat[o] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (req_val[i] && (req_dst[i*SEL_W +: SEL_W] == SEL_W'(o))) begin
                    req_mat[o][i] = 1'b1;
                end
            end
            if (req_val[i] && (32'(req_dst[i*SEL_W +: SEL_W]) >= NUM_PORTS)) begin
                dst_bad[i] = 1'b1;
            end
        end
    end

    // Round-robin pick per output: first requester after last[o], wrapping
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
                if (!gnt_vld[o] &&
                    req_mat[o][SEL_W'((32'(last_q[o]) + k) % NUM_PORTS)]) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = SEL_W'((32'(last_q[o]) + k) % NUM_PORTS);
                end
            end
        end
    end

    // Handshake and crossbar select from the locked owner of each output
    always_comb begin
        req_rdy = '0;
        out_val = '0;
        out_sel = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == ST_BUSY) begin
                out_val[o] = req_val[owner_q[o]] && out_rdy[o];
                out_sel[o*SEL_W +: SEL_W] = owner_q[o];
                if (out_val[o]) begin
                    req_rdy[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    // Next state: grant when idle, release after the tail flit fires
    always_comb begin
        bad_dst_d = bad_dst_q | (|dst_bad);
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            last_d[o]  = last_q[o];
            if (state_q[o] == ST_IDLE) begin
                if (gnt_vld[o]) begin
                    state_d[o] = ST_BUSY;
                    owner_d[o] = gnt_idx[o];
                end
            end else if (out_val[o] && req_last[owner_q[o]]) begin
                state_d[o] = ST_IDLE;
                last_d[o]  = owner_q[o];
            end
        end
    end

    // State registers; reset gives input 0 first priority everywhere
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                last_q[o]  <= LAST_RST;
            end
            bad_dst_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                last_q[o]  <= last_d[o];
            end
            bad_dst_q <= bad_dst_d;
        end
    end

    assign bad_dst = bad_dst_q;

endmodule

// File: tb/tb_router_sw_alloc.sv
// Bench for router_sw_alloc: flit sources per input, expected transfers
// (output, source, cycle) queued by the stimulus, checked by a monitor.
module tb_router_sw_alloc;

    localparam int unsigned NP = 5;
    localparam int unsigned SW = 3;

    logic               clk;
    logic               srst;
    logic [NP-1:0]      req_val;
    logic [NP*SW-1:0]   req_dst;
    logic [NP-1:0]      req_last;
    logic [NP-1:0]      req_rdy;
    logic [NP-1:0]      out_rdy;
    logic [NP-1:0]      out_val;
    logic [NP*SW-1:0]   out_sel;
    logic               bad_dst;

    router_sw_alloc #(.NUM_PORTS(NP), .SEL_W(SW)) dut (
        .clk      (clk),
        .srst     (srst),
        .req_val  (req_val),
        .req_dst  (req_dst),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .out_rdy  (out_rdy),
        .out_val  (out_val),
        .out_sel  (out_sel),
        .bad_dst  (bad_dst)
    );

    typedef struct {
        int out;
        int src;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;
    logic chk_sel0 = 1'b0;
    logic exp_bad = 1'b0;
    logic done = 1'b0;

    // Source model state
    int src_dst [NP];
    int src_len [NP];
    int src_left[NP];
    int src_pkts[NP];
    logic [NP-1:0] hold;
    logic [NP-1:0] took;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int o, input int s, input int c);
        exp_t e;
        e.out = o; e.src = s; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req_val[i]  = (src_left[i] > 0) && !hold[i];
            req_last[i] = (src_left[i] == 1);
            req_dst[i*SW +: SW] = SW'(src_dst[i]);
        end
    endtask

    task automatic load(input int i, input int d, input int len, input int npk);
        src_dst[i]  = d;
        src_len[i]  = len;
        src_left[i] = len;
        src_pkts[i] = npk - 1;
    endtask

    // One clock: note which inputs popped, then advance sources
    task automatic tick();
        @(negedge clk);
        took = req_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (took[i] === 1'b1 && src_left[i] > 0) begin
                src_left[i]--;
                if (src_left[i] == 0 && src_pkts[i] > 0) begin
                    src_pkts[i]--;
                    src_left[i] = src_len[i];
                end
            end
        end
        drive();
    endtask

    // Monitor: pop expected transfers as outputs fire, check side signals
    logic [NP-1:0] rdy_exp;
    logic [SW-1:0] sel;
    exp_t          e;
    always @(negedge clk) begin
        if (mon_en) begin
            rdy_exp = '0;
            for (int o = 0; o < NP; o++) begin
                sel = out_sel[o*SW +: SW];
                if (out_val[o] !== 1'b0) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_xfer cyc=%0d out=%0d sel=%0d, want no transfer", cyc, o, sel);
                    end else begin
                        e = exp_q.pop_front();
                        rdy_exp[e.src] = 1'b1;
                        if (e.out != o || int'(sel) != e.src || e.cyc != cyc) begin
                            bad++;
                            $display("FAIL xfer got out=%0d sel=%0d cyc=%0d, want out=%0d sel=%0d cyc=%0d",
                                     o, sel, cyc, e.out, e.src, e.cyc);
                        end
                    end
                end
                if (chk_sel0) begin
                    total++;
                    if (sel !== '0) begin
                        bad++;
                        $display("FAIL idle_sel cyc=%0d out=%0d got %0d want 0", cyc, o, sel);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_xfer cyc=%0d want out=%0d sel=%0d at cyc=%0d", cyc, e.out, e.src, e.cyc);
            end
            total++;
            if (req_rdy !== rdy_exp) begin
                bad++;
                $display("FAIL req_rdy cyc=%0d got %b want %b", cyc, req_rdy, rdy_exp);
            end
            total++;
            if (bad_dst !== exp_bad) begin
                bad++;
                $display("FAIL bad_dst cyc=%0d got %b want %b", cyc, bad_dst, exp_bad);
            end
            if (done) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL drain got %0d pending want 0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    int b;
    initial begin
        srst = 1'b1;
        req_val = '0; req_dst = '0; req_last = '0;
        out_rdy = '1; hold = '0; took = '0;
        for (int i = 0; i < NP; i++) load(i, 0, 0, 1);
        tick(); tick();
        mon_en = 1'b1;
        chk_sel0 = 1'b1;
        tick();
        srst = 1'b0;
        tick();

        // Single 4-flit packet, input 2 -> output 3
        chk_sel0 = 1'b0;
        b = cyc;
        load(2, 3, 4, 1); drive();
        for (int c = 1; c <= 4; c++) push(3, 2, b + c);
        repeat (7) tick();

        // Contention on output 1: inputs 0,1,4, two 2-flit packets each
        b = cyc;
        load(0, 1, 2, 2); load(1, 1, 2, 2); load(4, 1, 2, 2); drive();
        begin
            int order[6];
            order = '{0, 1, 4, 0, 1, 4};
            for (int p = 0; p < 6; p++) begin
                push(1, order[p], b + 1 + 3*p);
                push(1, order[p], b + 2 + 3*p);
            end
        end
        repeat (20) tick();

        // Parallel: input 0 -> out 2, input 3 -> out 4, 3 flits each
        b = cyc;
        load(0, 2, 3, 1); load(3, 4, 3, 1); drive();
        for (int c = 1; c <= 3; c++) begin
            push(2, 0, b + c);
            push(4, 3, b + c);
        end
        repeat (6) tick();

        // Backpressure and source gaps: input 1 -> out 1, 4 flits
        b = cyc;
        load(1, 1, 4, 1);
        begin
            logic [7:0] rdy_pat;
            logic [7:0] hold_pat;
            rdy_pat  = 8'b1101_1101;   // bit k applies in cycle b+k
            hold_pat = 8'b0010_1000;
            push(1, 1, b + 2); push(1, 1, b + 4);
            push(1, 1, b + 6); push(1, 1, b + 7);
            for (int k = 0; k < 8; k++) begin
                out_rdy[1] = rdy_pat[k];
                hold[1]    = hold_pat[k];
                drive();
                tick();
            end
        end
        out_rdy = '1; hold = '0; drive();
        repeat (3) tick();

        // Invalid destination on input 1; input 2 -> out 0 unaffected
        b = cyc;
        load(1, 6, 1, 1); load(2, 0, 1, 1); drive();
        push(0, 2, b + 1);
        tick();
        exp_bad = 1'b1;
        repeat (3) tick();
        src_left[1] = 0;
        srst = 1'b1;
        drive();
        tick();
        srst = 1'b0;
        exp_bad = 1'b0;
        chk_sel0 = 1'b1;
        tick();
        chk_sel0 = 1'b0;
        repeat (2) tick();

        // Reset during flit 2 of 4, then contention restarts at input 0
        b = cyc;
        load(3, 2, 4, 1); drive();
        push(2, 3, b + 1); push(2, 3, b + 2);
        tick();
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk_sel0 = 1'b1;
        b = cyc;
        load(3, 2, 1, 1); load(0, 2, 1, 1); drive();
        push(2, 0, b + 1); push(2, 3, b + 3);
        tick();
        chk_sel0 = 1'b0;
        repeat (5) tick();

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_end got no summary want summary");
        $fatal(1);
    end

endmodule

// File: doc/router_sw_alloc.md
# router_sw_alloc

Switch allocator for the router's crossbar. Each of NUM_PORTS input FIFO heads requests one output port. The block runs one round-robin arbiter per output port and locks each grant for a whole packet (wormhole), releasing it after the tail flit. It generates the per-flit valid/ready handshake and the crossbar select between the input FIFOs' read side and the output FIFOs' write side.

## Interface
- NUM_PORTS, 5, number of input and output ports (2..8)
- SEL_W, $clog2(NUM_PORTS), width of a port index
- clk  in  1  clock, all logic rising-edge
- srst  in  1  synchronous reset, active-high
- req_val  in  NUM_PORTS  input i head flit valid (input FIFO not empty)
- req_dst  in  NUM_PORTS*SEL_W  destination of input i head flit; slice i = [i*SEL_W +: SEL_W]
- req_last  in  NUM_PORTS  input i head flit is packet tail
- req_rdy  out  NUM_PORTS  pop input i FIFO this cycle (flit transferred)
- out_rdy  in  NUM_PORTS  output o FIFO can accept a flit (not full)
- out_val  out  NUM_PORTS  push output o FIFO this cycle
- out_sel  out  NUM_PORTS*SEL_W  crossbar source index for output o
- bad_dst  out  1  sticky: some req_val input presented req_dst >= NUM_PORTS

## Operation
- Per output o: state IDLE/BUSY, owner[o] (SEL_W), last[o] (last granted input, SEL_W).
- Input i requests output o when req_val[i] && req_dst[i]==o. Sources must hold req_dst stable from the head flit until the tail transfers.
- IDLE: if any input requests o, grant the first requester searching last[o]+1, last[o]+2, ... wrapping modulo NUM_PORTS. Register owner[o] and go BUSY at the next edge. No requester: stay IDLE.
- BUSY: out_val[o] = req_val[owner[o]] && out_rdy[o]; req_rdy[owner[o]] = same term; out_sel[o] = owner[o].
- A flit fires when out_val[o]=1. If req_last[owner[o]] is also 1: go IDLE, last[o] <= owner[o].
- An input has exactly one destination, so at most one output can own it. req_rdy[i] is the OR over outputs, and at most one term is ever active.
- Outputs with no owner: out_val=0, out_sel=0. Inputs with no owner: req_rdy=0.
- Invalid destination (req_val[i] && req_dst[i] >= NUM_PORTS): never granted, so the input stalls. bad_dst is set and held until srst.
- Single-flit packet (head is tail): one grant, one transfer, release.
- All outputs are evaluated independently and in parallel. Several packets can be in flight to distinct outputs at once.

## Timing
- Reset values: all states IDLE; owner=0; last=NUM_PORTS-1, so input 0 has first priority; bad_dst=0. Outputs req_rdy=0, out_val=0, out_sel=0 during and after reset until a grant.
- srst asserted mid-packet: grants are dropped on the next edge. The block performs no flit cleanup; the surrounding FIFOs are reset by the same srst.
- Arbitration latency: head arrives in cycle t, grant is registered at the end of t, and the first flit can transfer in t+1.
- Streaming: one flit per cycle per output while req_val and out_rdy stay high.
- Release gap: tail fires in cycle t, the output is IDLE in t+1 (re-arbitrates), and the next packet's first flit can transfer in t+2. There is exactly one bubble per packet per output.
- out_val, req_rdy and out_sel are combinational from registered state plus req_val/out_rdy/req_last. There is no path from req_dst to the handshake outputs.
- out_rdy low stalls the transfer with no state change. req_val low inside a packet stalls it and ownership is kept.

## Test plan
- Reset then single packet: input 2, dst 3, 4 flits, out_rdy=1. Expect grant cycle, then out_val[3]=req_rdy[2]=1 for 4 consecutive cycles, out_sel[3]=2, then IDLE.
- Contention fairness: inputs 0, 1 and 4 all send 2-flit packets to output 1 continuously. Expect grant order 0, 1, 4, 0, 1, 4 with one bubble between packets.
- Parallel traffic: input 0 to out 2 and input 3 to out 4 simultaneously. Expect both outputs to stream in the same cycles with independent out_sel values.
- Backpressure and gaps: toggle out_rdy[1] and req_val of the owner mid-packet. Expect no transfer whenever either is 0, ownership retained, and flit count conserved.
- Bad destination: NUM_PORTS=5, input 1 presents dst 6. Expect bad_dst=1 next cycle and req_rdy[1] held 0. Other inputs are unaffected, and srst clears bad_dst.
- Reset mid-packet: assert srst during flit 2 of 4. Next cycle all out_val/req_rdy=0 and last=NUM_PORTS-1, so input 0 wins the next contention.
